// File: rtl/digit_scan_multiplexer.sv
// rtl/digit_scan_multiplexer.sv - time-multiplexed digit scanner with blanking and per-digit enables
module digit_scan_multiplexer #(
    parameter int NUM_DIGITS       = 4,
    parameter int DWELL_CYCLES     = 24000,
    parameter int BLANK_CYCLES     = 240,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [4*NUM_DIGITS-1:0]       digits,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [3:0]                    hex_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] AN_IDLE = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx_n;
    logic [3:0]              hex_n;
    logic                    fs_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    first, first_n;

    logic [IW-1:0]           sel, lowest, cand;
    logic [IW+1:0]           hsel;
    logic                    found;
    logic                    take;
    int                      base, c;

    // First enabled digit at or after the search base; "first" makes the
    // post-reset search start at index 0 inclusive instead of digit_idx+1.
    always_comb begin
        base  = first ? 0 : int'(digit_idx) + 1;
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        c     = 0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            c = base + k;
            if (c >= NUM_DIGITS) c = c - NUM_DIGITS;
            cand = IW'(c);
            if (!found && digit_en[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        lowest = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (digit_en[k]) lowest = IW'(k);
        end
        hsel = {sel, 2'b00};
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = digit_idx;
        hex_n   = hex_out;
        fs_n    = 1'b0;
        first_n = first;
        take    = 1'b0;
        case (state)
            BLANK: begin
                if (cnt <= CW'(1)) begin
                    if (found) take = 1'b1;
                    else       cnt_n = BLANK_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            SHOW: begin
                if (!digit_en[digit_idx]) begin
                    state_n = BLANK;
                    cnt_n   = BLANK_LOAD;
                end else if (cnt <= CW'(1)) begin
                    if (BLANK_CYCLES == 0) begin
                        take = 1'b1;
                    end else begin
                        state_n = BLANK;
                        cnt_n   = BLANK_LOAD;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = BLANK;
                cnt_n   = BLANK_LOAD;
            end
        endcase
        if (take) begin
            state_n = SHOW;
            cnt_n   = DWELL_LOAD;
            idx_n   = sel;
            hex_n   = digits[hsel +: 4];
            fs_n    = (sel == lowest);
            first_n = 1'b0;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_n[i] = ((state_n == SHOW) && (idx_n == IW'(i))) ^ ANODE_ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BLANK;
            cnt         <= BLANK_LOAD;
            digit_idx   <= '0;
            hex_out     <= 4'h0;
            frame_start <= 1'b0;
            an          <= AN_IDLE;
            first       <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            digit_idx   <= idx_n;
            hex_out     <= hex_n;
            frame_start <= fs_n;
            an          <= an_n;
            first       <= first_n;
        end
    end

endmodule

// File: tb/tb_digit_scan_multiplexer.sv
// tb/tb_digit_scan_multiplexer.sv - directed bench for digit_scan_multiplexer
module tb_digit_scan_multiplexer;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic [3:0]  an;
    logic [3:0]  hex_out;
    logic [1:0]  digit_idx;
    logic        frame_start;

    logic [7:0]  digits2;
    logic [1:0]  digit_en2;
    logic [1:0]  an2;
    logic [3:0]  hex_out2;
    logic [0:0]  digit_idx2;
    logic        frame_start2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    digit_scan_multiplexer #(
        .NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1'b1)
    ) u_dut (
        .clk(clk), .reset(reset), .digits(digits), .digit_en(digit_en),
        .an(an), .hex_out(hex_out), .digit_idx(digit_idx), .frame_start(frame_start)
    );

    digit_scan_multiplexer #(
        .NUM_DIGITS(2), .DWELL_CYCLES(5), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1'b1)
    ) u_dut2 (
        .clk(clk), .reset(reset2), .digits(digits2), .digit_en(digit_en2),
        .an(an2), .hex_out(hex_out2), .digit_idx(digit_idx2), .frame_start(frame_start2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {an, hex_out, frame_start} after one clock
    task automatic step(input string tag, input logic [3:0] e_an, input logic [3:0] e_hex, input logic e_fs);
        tick();
        check(tag, {23'd0, an, hex_out, frame_start}, {23'd0, e_an, e_hex, e_fs});
    endtask

    task automatic show(input string tag, input int d, input logic [3:0] e_hex, input logic e_fs);
        logic [3:0] a;
        a = ~(4'b0001 << d);
        step(tag, a, e_hex, e_fs);
        for (int i = 0; i < 3; i++) step(tag, a, e_hex, 1'b0);
    endtask

    task automatic do_reset(input logic [3:0] en, input logic [15:0] dg);
        reset = 1'b1; digit_en = en; digits = dg;
        tick();
        check("reset_state", {22'd0, an, hex_out, frame_start, digit_idx}, {22'd0, 4'b1111, 4'h0, 1'b0, 2'd0});
        reset = 1'b0;
    endtask

    // At most one anode active on every cycle, both instances
    always @(negedge clk) begin
        checks++;
        assert (($countones(~an) <= 1) && ($countones(~an2) <= 1)) else begin
            errors++;
            $error("FAIL onehot: an=%b an2=%b", an, an2);
        end
    end

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        digits = 16'h4321; digit_en = 4'b1111;
        digits2 = 8'h21; digit_en2 = 2'b11;

        // full scan of all four digits, then wrap with frame_start
        do_reset(4'b1111, 16'h4321);
        step("t1_blank", 4'b1111, 4'h0, 1'b0);
        for (int d = 0; d < 4; d++) begin
            show("t1_show", d, 4'(d + 1), d == 0);
            step("t1_gap", 4'b1111, 4'(d + 1), 1'b0);
            step("t1_gap", 4'b1111, 4'(d + 1), 1'b0);
        end
        step("t1_wrap", 4'b1110, 4'h1, 1'b1);
        check("t1_idx", {30'd0, digit_idx}, 32'd0);

        // sparse enable mask 0101
        do_reset(4'b0101, 16'h4321);
        step("t2_blank", 4'b1111, 4'h0, 1'b0);
        show("t2_d0", 0, 4'h1, 1'b1);
        step("t2_gap", 4'b1111, 4'h1, 1'b0);
        step("t2_gap", 4'b1111, 4'h1, 1'b0);
        show("t2_d2", 2, 4'h3, 1'b0);
        step("t2_gap", 4'b1111, 4'h3, 1'b0);
        step("t2_gap", 4'b1111, 4'h3, 1'b0);
        step("t2_d0b", 4'b1110, 4'h1, 1'b1);

        // nothing enabled: idle until a digit appears
        do_reset(4'b0000, 16'h4321);
        for (int i = 0; i < 10; i++) step("t3_idle", 4'b1111, 4'h0, 1'b0);
        digit_en = 4'b0010;
        step("t3_wait", 4'b1111, 4'h0, 1'b0);
        step("t3_on", 4'b1101, 4'h2, 1'b1);
        check("t3_idx", {30'd0, digit_idx}, 32'd1);

        // enable drop mid-SHOW, digits change mid-SHOW
        do_reset(4'b1111, 16'h4321);
        step("t4_blank", 4'b1111, 4'h0, 1'b0);
        step("t4_d0", 4'b1110, 4'h1, 1'b1);
        digit_en = 4'b1110;
        step("t4_drop", 4'b1111, 4'h1, 1'b0);
        step("t4_gap", 4'b1111, 4'h1, 1'b0);
        step("t4_d1", 4'b1101, 4'h2, 1'b1);
        digits = 16'h8765;
        for (int i = 0; i < 3; i++) step("t4_hold", 4'b1101, 4'h2, 1'b0);
        step("t4_gap2", 4'b1111, 4'h2, 1'b0);
        step("t4_gap2", 4'b1111, 4'h2, 1'b0);
        step("t4_d2", 4'b1011, 4'h7, 1'b0);

        // reset on the second SHOW cycle of digit 2
        do_reset(4'b1111, 16'h4321);
        for (int i = 0; i < 13; i++) tick();
        step("t5_d2", 4'b1011, 4'h3, 1'b0);
        step("t5_d2b", 4'b1011, 4'h3, 1'b0);
        reset = 1'b1;
        tick();
        check("t5_rst", {22'd0, an, hex_out, frame_start, digit_idx}, {22'd0, 4'b1111, 4'h0, 1'b0, 2'd0});
        reset = 1'b0;
        step("t5_blank", 4'b1111, 4'h0, 1'b0);
        step("t5_d0", 4'b1110, 4'h1, 1'b1);

        // two digits, no blanking: continuous alternation
        reset2 = 1'b1;
        tick();
        check("t6_rst", {30'd0, an2}, {30'd0, 2'b11});
        reset2 = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) begin
                tick();
                check("t6_alt", {26'd0, an2, hex_out2},
                      {26'd0, (r % 2 == 0) ? 2'b10 : 2'b01, (r % 2 == 0) ? 4'h1 : 4'h2});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digit_scan_multiplexer.md
DIGIT_SCAN_MULTIPLEXER -- requirements
Module: digit_scan_multiplexer

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 2..8.
REQ-002 Parameter DWELL_CYCLES, default 24000, clocks each digit is lit; legal range >=1.
REQ-003 Parameter BLANK_CYCLES, default 240, clocks all anodes are off between digits; legal range >=0.
REQ-004 Parameter ANODE_ACTIVE_LOW, default 1, 1 = anode on when 0; 0 = anode on when 1.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset  input  1  reset: one clock, synchronous and active-high.
REQ-007 digits  input  4*NUM_DIGITS  packed hex values; digit i = digits[4i+3:4i].
REQ-008 digit_en  input  NUM_DIGITS  per-digit enable mask; bit i = 1 means digit i is scanned.
REQ-009 an  output  NUM_DIGITS  registered anode drives, polarity per ANODE_ACTIVE_LOW.
REQ-010 hex_out  output  4  registered nibble for the lit digit, to the external seven-segment decoder.
REQ-011 digit_idx  output  $clog2(NUM_DIGITS)  index of the current or most recent lit digit.
REQ-012 frame_start  output  1  one-cycle pulse marking the start of each scan frame.

Function
REQ-013 The FSM SHALL have exactly two states: BLANK (all anodes inactive) and SHOW (only anode digit_idx active).
REQ-014 One down-counter SHALL time both states; width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1); no wrap or overflow permitted.
REQ-015 BLANK SHALL last exactly BLANK_CYCLES cycles, then enter SHOW for the selected digit.
REQ-016 SHOW SHALL last exactly DWELL_CYCLES cycles, then enter BLANK and select the next digit.
REQ-017 If BLANK_CYCLES = 0, the FSM SHALL skip BLANK and go SHOW-to-SHOW with no anode-off cycle.
REQ-018 Next digit SHALL be the first enabled index searching upward from digit_idx+1 modulo NUM_DIGITS.
REQ-019 If digit_idx is the only enabled digit, the next digit SHALL be digit_idx itself, with blanking still applied.
REQ-020 digit_en SHALL be sampled when the next digit is selected.
REQ-021 If digit_en is all zero at selection time, the FSM SHALL remain in BLANK.
REQ-022 While in that all-zero BLANK, the FSM SHALL reload the BLANK count and re-check digit_en every BLANK period.
REQ-023 If digit_en[digit_idx] falls during SHOW, the FSM SHALL enter BLANK on the next edge and select the next digit normally.
REQ-024 hex_out SHALL load digits[digit_idx] on entry to SHOW and hold it through SHOW and the following BLANK.
REQ-025 Changes to digits mid-SHOW SHALL NOT affect hex_out until the next SHOW entry.
REQ-026 frame_start SHALL pulse high for one cycle, coincident with an, on entry to SHOW for the lowest-index enabled digit.
REQ-027 No more than one anode SHALL be active in any cycle.
REQ-028 an SHALL change only on clock edges, with no combinational path from inputs to an.
REQ-029 Digit-to-digit period SHALL equal BLANK_CYCLES + DWELL_CYCLES clocks.

Reset
REQ-030 While reset is high at a rising edge, the block SHALL set state = BLANK, counter = BLANK_CYCLES, digit_idx = 0, hex_out = 0, frame_start = 0.
REQ-031 Under the same reset condition, an SHALL be set to all-inactive.
REQ-032 Reset asserted mid-SHOW SHALL turn all anodes off at that same edge.
REQ-033 After reset deasserts, the first SHOW SHALL select the lowest enabled index, searching from index 0 inclusive.

Verification
REQ-034 Setup NUM_DIGITS=4, DWELL=4, BLANK=2, active-low, en=1111, digits=16'h4321 -> an: 1111 x2, 1110 x4 (hex_out=1, frame_start on first cycle), 1111 x2, 1101 x4 (hex_out=2), ... digit 3 -> back to digit 0 with frame_start.
REQ-035 Same setup, en=0101 -> only 1110 (hex 1) and 1011 (hex 3) lit, alternating, 2 blank cycles between; digits 1 and 3 never lit.
REQ-036 en=0000 -> an=1111 indefinitely, frame_start never pulses; set en=0010 -> within 2 cycles an=1101, hex_out=2, frame_start pulses.
REQ-037 During SHOW of digit 0, clear en[0] -> an=1111 on next edge, 2 blank cycles, then digit 1 for 4 cycles; digits change mid-SHOW -> hex_out unchanged until next SHOW.
REQ-038 Assert reset on the 2nd SHOW cycle of digit 2 -> next edge an=1111, digit_idx=0, hex_out=0; after release, BLANK 2 cycles, then digit 0.
REQ-039 NUM_DIGITS=2, BLANK=0, DWELL=5 -> an alternates 10/01 every 5 cycles, never 11 or 00; checker asserts one-hot-or-idle an every cycle in all tests.
